// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: blank pattern,
// hex-to-segment table and lookup helper. Patterns are active-low, gfedcba.
package seg7_pkg;

  // All segments and the decimal point dark (active-low outputs).
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index n holds the active-low gfedcba pattern for hex digit n.
  // The packed concatenation lists entry 15 first and entry 0 last.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  // Look up the seven segment bits (gfedcba, active-low) for one nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble + decimal point to 8-bit active-low segment pattern
// ordered {dp,g,f,e,d,c,b,a}.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dot_i,
  output logic [7:0] seg_o
);

  // dp is active-low, so a lit dot drives bit 7 to zero.
  assign seg_o = {~dot_i, hex_to_seg(nibble_i)};

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Each digit owns a slot of DIGIT_PERIOD clocks; the first clock of every slot
// is dead time with all anodes off. Display data lives in a shadow set that is
// only reloaded at the frame boundary so a frame is never torn. Brightness is
// a free-running PWM gating the anode.
// Optional build macro: LEADING_ZERO_SUPPRESS_EN blanks leading zero digits
// (never digit 0, never a digit whose decimal point is lit) at capture time.
module seven_seg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_PERIOD = 100000,
  parameter int BRIGHT_W     = 4
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [4*NUM_DIGITS-1:0] DIGITS,
  input  logic [NUM_DIGITS-1:0]   DOTS,
  input  logic [NUM_DIGITS-1:0]   BLANK,
  input  logic [BRIGHT_W-1:0]     BRIGHTNESS,
  input  logic                    LOAD,
  output logic [7:0]              SEG_OUT,
  output logic [NUM_DIGITS-1:0]   AN_OUT,
  output logic                    FRAME_DONE
);

  localparam int PRE_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIGIT_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Scan timing state
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic                fd_q, fd_d;
  logic                slot_end;
  logic                frame_wrap;

  // Load handshake and shadow set
  logic                          load_pend_q, load_pend_d;
  logic                          capture;
  logic [NUM_DIGITS-1:0][3:0]    dig_sh_q, dig_sh_d;
  logic [NUM_DIGITS-1:0]         dots_sh_q, dots_sh_d;
  logic [NUM_DIGITS-1:0]         blank_sh_q, blank_sh_d;
  logic [BRIGHT_W-1:0]           bright_sh_q, bright_sh_d;
  logic [NUM_DIGITS-1:0]         blank_eff;

  // Output stage
  logic [3:0]            cur_nib;
  logic                  cur_dot;
  logic                  cur_blank;
  logic [7:0]            dec_seg;
  logic                  pwm_on;
  logic                  dead_time;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

`ifdef LEADING_ZERO_SUPPRESS_EN
  // Bit i (i >= 1) is set when digits i..NUM_DIGITS-1 are all zero and the
  // digit's own decimal point is not requested. Digit 0 always stays visible.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(
    input logic [NUM_DIGITS-1:0][3:0] digits,
    input logic [NUM_DIGITS-1:0]      dots
  );
    logic [NUM_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (digits[i] == 4'h0);
      mask[i]  = all_zero & ~dots[i];
    end
    return mask;
  endfunction

  assign blank_eff = BLANK | lz_mask(DIGITS, DOTS);
`else
  assign blank_eff = BLANK;
`endif

  // Prescaler, digit index, PWM counter and frame-done next state.
  always_comb begin
    slot_end   = (pre_q == PRE_LAST);
    frame_wrap = slot_end && (idx_q == IDX_LAST);
    pre_d      = slot_end ? '0 : pre_q + PRE_W'(1);
    idx_d      = idx_q;
    if (slot_end) begin
      idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
    end
    pwm_d = pwm_q + BRIGHT_W'(1);
    fd_d  = frame_wrap;
  end

  // A pending or same-cycle LOAD is honoured only as the index wraps to 0.
  always_comb begin
    capture     = frame_wrap && (load_pend_q || LOAD);
    load_pend_d = capture ? 1'b0 : (load_pend_q || LOAD);
    dig_sh_d    = dig_sh_q;
    dots_sh_d   = dots_sh_q;
    blank_sh_d  = blank_sh_q;
    bright_sh_d = bright_sh_q;
    if (capture) begin
      dig_sh_d    = DIGITS;
      dots_sh_d   = DOTS;
      blank_sh_d  = blank_eff;
      bright_sh_d = BRIGHTNESS;
    end
  end

  assign cur_nib   = dig_sh_q[idx_q];
  assign cur_dot   = dots_sh_q[idx_q];
  assign cur_blank = blank_sh_q[idx_q];

  seg7_decoder u_decoder (
    .nibble_i (cur_nib),
    .dot_i    (cur_dot),
    .seg_o    (dec_seg)
  );

  // Segment pattern and single active anode for the current slot.
  always_comb begin
    pwm_on    = (&bright_sh_q) || (pwm_q < bright_sh_q);
    dead_time = (pre_q == '0);
    seg_d     = cur_blank ? SEG_BLANK : dec_seg;
    an_d      = '1;
    if (!cur_blank && pwm_on && !dead_time) begin
      an_d[idx_q] = 1'b0;
    end
  end

  // Scan timing registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_q <= '0;
      idx_q <= '0;
      pwm_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      pwm_q <= pwm_d;
      fd_q  <= fd_d;
    end
  end

  // Shadow set and pending-load flag; reset leaves the display blanked.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      load_pend_q <= 1'b0;
      dig_sh_q    <= '0;
      dots_sh_q   <= '0;
      blank_sh_q  <= '1;
      bright_sh_q <= '1;
    end else begin
      load_pend_q <= load_pend_d;
      dig_sh_q    <= dig_sh_d;
      dots_sh_q   <= dots_sh_d;
      blank_sh_q  <= blank_sh_d;
      bright_sh_q <= bright_sh_d;
    end
  end

  // Registered display outputs, one cycle behind the scan state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign SEG_OUT    = seg_q;
  assign AN_OUT     = an_q;
  assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (4 digits, 8-cycle slots,
// 4-bit brightness). A cycle-count based reference model predicts every
// output each cycle; literal checks at known frame positions pin the model.
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int P     = 8;
  localparam int BW    = 4;
  localparam int FRAME = N * P;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        LOAD = 1'b0;
  logic [15:0] DIGITS = '0;
  logic [3:0]  DOTS = '0;
  logic [3:0]  BLANK = '0;
  logic [3:0]  BRIGHTNESS = '0;
  logic [7:0]  SEG_OUT;
  logic [3:0]  AN_OUT;
  logic        FRAME_DONE;

  int checks   = 0;
  int failures = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .DIGIT_PERIOD (P),
    .BRIGHT_W     (BW)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .DIGITS     (DIGITS),
    .DOTS       (DOTS),
    .BLANK      (BLANK),
    .BRIGHTNESS (BRIGHTNESS),
    .LOAD       (LOAD),
    .SEG_OUT    (SEG_OUT),
    .AN_OUT     (AN_OUT),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int         t;
  logic [3:0] m_dig [N];
  logic [3:0] m_dots, m_blank, m_bright, m_lz;
  bit         m_pend;
  logic [7:0] m_seg = 8'hFF;
  logic [3:0] m_an  = 4'hF;
  logic       m_fd  = 1'b0;
  int         m_pre, m_idx, m_pw;
  bit         m_wrap, m_cap, m_allz;

  // t counts clock edges since reset release; slot, digit and PWM phase
  // follow directly from it.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      t = 0;
      for (int i = 0; i < N; i++) m_dig[i] = 4'h0;
      m_dots   = 4'h0;
      m_blank  = 4'hF;
      m_bright = 4'hF;
      m_pend   = 1'b0;
      m_seg    = 8'hFF;
      m_an     = 4'hF;
      m_fd     = 1'b0;
    end else begin
      m_pre  = t % P;
      m_idx  = (t / P) % N;
      m_pw   = t % 16;
      m_wrap = ((t % FRAME) == FRAME - 1);
      m_fd   = m_wrap;
      if (m_blank[m_idx]) begin
        m_seg = 8'hFF;
        m_an  = 4'hF;
      end else begin
        m_seg = {~m_dots[m_idx], seg_tab[m_dig[m_idx]][6:0]};
        if (m_pre != 0 && (m_bright == 4'hF || m_pw < int'(m_bright)))
          m_an = ~(4'b0001 << m_idx);
        else
          m_an = 4'hF;
      end
      m_cap  = m_wrap && (m_pend || LOAD);
      m_pend = m_cap ? 1'b0 : (m_pend || LOAD);
      if (m_cap) begin
        for (int i = 0; i < N; i++) m_dig[i] = DIGITS[4*i +: 4];
        m_lz = 4'h0;
`ifdef LEADING_ZERO_SUPPRESS_EN
        m_allz = 1'b1;
        for (int i = N - 1; i >= 1; i--) begin
          if (DIGITS[4*i +: 4] != 4'h0) m_allz = 1'b0;
          if (m_allz && !DOTS[i]) m_lz[i] = 1'b1;
        end
`endif
        m_dots   = DOTS;
        m_blank  = BLANK | m_lz;
        m_bright = BRIGHTNESS;
      end
      t++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    check("model_seg", 32'(SEG_OUT), 32'(m_seg));
    check("model_an", 32'(AN_OUT), 32'(m_an));
    check("model_frame_done", 32'(FRAME_DONE), 32'(m_fd));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] dp,
                        input logic [3:0] bl, input logic [3:0] br);
    DIGITS = d; DOTS = dp; BLANK = bl; BRIGHTNESS = br;
  endtask

  task automatic pulse_load();
    LOAD = 1'b1;
    tick(1);
    LOAD = 1'b0;
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    while (!FRAME_DONE && n < 200) begin
      tick(1);
      n++;
    end
    check("frame_done_wait", 32'(FRAME_DONE), 32'd1);
  endtask

  // Starting at the FRAME_DONE sample: slot s, cycle c is visible c+8s+1
  // samples later. Checks the dead-time cycle and the first lit cycle of
  // each slot (full brightness), ending on the next FRAME_DONE sample.
  task automatic frame_lits(input logic [31:0] es, input logic [15:0] ea);
    for (int s = 0; s < N; s++) begin
      tick(1);
      check("lit_seg_dead", 32'(SEG_OUT), 32'(es[8*s +: 8]));
      check("lit_an_dead", 32'(AN_OUT), 32'h0000000F);
      tick(1);
      check("lit_seg", 32'(SEG_OUT), 32'(es[8*s +: 8]));
      check("lit_an", 32'(AN_OUT), 32'(ea[4*s +: 4]));
      tick(6);
    end
    check("lit_frame_done", 32'(FRAME_DONE), 32'd1);
  endtask

  initial begin
    int n;
    // Reset state
    #1 RESET_N = 1'b0;
    tick(3);
    check("reset_seg", 32'(SEG_OUT), 32'h000000FF);
    check("reset_an", 32'(AN_OUT), 32'h0000000F);
    check("reset_fd", 32'(FRAME_DONE), 32'd0);
    RESET_N = 1'b1;

    // 1: no LOAD, display dark, FRAME_DONE period
    wait_fd();
    tick(1);
    n = 1;
    while (!FRAME_DONE && n < 100) begin
      tick(1);
      n++;
    end
    check("fd_period", 32'(n), 32'd32);
    tick(70);
    check("dark_seg", 32'(SEG_OUT), 32'h000000FF);
    check("dark_an", 32'(AN_OUT), 32'h0000000F);

    // 2: basic frame of 12AF
    set_in(16'h12AF, 4'h0, 4'h0, 4'hF);
    pulse_load();
    wait_fd();
    frame_lits({8'hF9, 8'hA4, 8'h88, 8'h8E}, {4'h7, 4'hB, 4'hD, 4'hE});

    // 3: mid-frame LOAD only shows after the boundary
    tick(12);
    set_in(16'h8888, 4'h0, 4'h0, 4'hF);
    pulse_load();
    tick(5);
    check("midframe_old_seg", 32'(SEG_OUT), 32'h000000A4);
    wait_fd();
    tick(1);
    check("newframe_seg", 32'(SEG_OUT), 32'h00000080);
    check("newframe_an_dead", 32'(AN_OUT), 32'h0000000F);
    tick(1);
    check("newframe_an", 32'(AN_OUT), 32'h0000000E);

    // 4: brightness 4 then 0
    set_in(16'h12AF, 4'h0, 4'h0, 4'h4);
    pulse_load();
    wait_fd();
    tick(2);
    check("pwm4_on_an", 32'(AN_OUT), 32'h0000000E);
    tick(3);
    check("pwm4_off_an", 32'(AN_OUT), 32'h0000000F);
    check("pwm4_seg", 32'(SEG_OUT), 32'h0000008E);
    set_in(16'h12AF, 4'h0, 4'h0, 4'h0);
    pulse_load();
    wait_fd();
    tick(2);
    check("pwm0_an", 32'(AN_OUT), 32'h0000000F);
    check("pwm0_seg", 32'(SEG_OUT), 32'h0000008E);
    tick(8);
    check("pwm0_an_s1", 32'(AN_OUT), 32'h0000000F);
    check("pwm0_seg_s1", 32'(SEG_OUT), 32'h00000088);

    // 5: dot on digit 2, blank digit 3
    set_in(16'h12AF, 4'b0100, 4'b1000, 4'hF);
    pulse_load();
    wait_fd();
    tick(10);
    check("dots_s1_seg", 32'(SEG_OUT), 32'h00000088);
    check("dots_s1_an", 32'(AN_OUT), 32'h0000000D);
    tick(8);
    check("dot_s2_seg", 32'(SEG_OUT), 32'h00000024);
    check("dot_s2_an", 32'(AN_OUT), 32'h0000000B);
    tick(8);
    check("blank_s3_seg", 32'(SEG_OUT), 32'h000000FF);
    check("blank_s3_an", 32'(AN_OUT), 32'h0000000F);

    // 6: leading zeros
    set_in(16'h0050, 4'h0, 4'h0, 4'hF);
    pulse_load();
    wait_fd();
`ifdef LEADING_ZERO_SUPPRESS_EN
    frame_lits({8'hFF, 8'hFF, 8'h92, 8'hC0}, {4'hF, 4'hF, 4'hD, 4'hE});
    set_in(16'h0000, 4'h0, 4'h0, 4'hF);
    pulse_load();
    wait_fd();
    frame_lits({8'hFF, 8'hFF, 8'hFF, 8'hC0}, {4'hF, 4'hF, 4'hF, 4'hE});
`else
    frame_lits({8'hC0, 8'hC0, 8'h92, 8'hC0}, {4'h7, 4'hB, 4'hD, 4'hE});
`endif

    // Randomized traffic, model checks every cycle
    for (int i = 0; i < 800; i++) begin
      DIGITS = 16'($urandom);
      if ($urandom_range(0, 2) == 0) DIGITS = DIGITS & 16'h00FF;
      if ($urandom_range(0, 3) == 0) DIGITS = 16'h0000;
      DOTS       = 4'($urandom);
      BLANK      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      BRIGHTNESS = 4'($urandom);
      LOAD       = ($urandom_range(0, 9) == 0);
      tick(1);
    end
    LOAD = 1'b0;

    // Asynchronous reset mid-slot
    set_in(16'h12AF, 4'h0, 4'h0, 4'hF);
    pulse_load();
    wait_fd();
    tick(3);
    #2 RESET_N = 1'b0;
    #1;
    check("async_reset_seg", 32'(SEG_OUT), 32'h000000FF);
    check("async_reset_an", 32'(AN_OUT), 32'h0000000F);
    check("async_reset_fd", 32'(FRAME_DONE), 32'd0);
    tick(2);
    RESET_N = 1'b1;
    tick(40);
    check("post_reset_dark_seg", 32'(SEG_OUT), 32'h000000FF);
    check("post_reset_dark_an", 32'(AN_OUT), 32'h0000000F);
    pulse_load();
    wait_fd();
    tick(2);
    check("post_reset_load_seg", 32'(SEG_OUT), 32'h0000008E);
    check("post_reset_load_an", 32'(AN_OUT), 32'h0000000E);
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
